// File: rtl/rv_md_pkg.sv
// Shared definitions for the iterative M-extension unit: op indices, FSM states, op decode helpers.
package rv_md_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FIX, ST_DONE} state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_x(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_y(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Lowest set bit wins; the decoder only ever drives a single bit.
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (oh[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/rv_md_step.sv
// One radix-2 step: conditional add + right shift for multiply, trial subtract + left shift for divide.
// Purely combinational; chained to retire several bits per cycle.
module rv_md_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rs;
  logic [XLEN:0] trial;

  always_comb begin
    sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, a_i} : '0);
    rs    = {hi_i, lo_i[XLEN-1]};
    trial = rs - {1'b0, a_i};
    if (is_div_i) begin
      // Partial remainder is always < 2*divisor, so the top bit of trial is a clean sign.
      if (!trial[XLEN]) begin
        hi_o = trial[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = rs[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/rv_muldiv_iter.sv
// Iterative RV32 M-extension unit; pending holds the sequencer for XLEN/BITS_PER_CYCLE+2 cycles, result valid in DONE.
// Optional RV_MD_EARLY_OUT_EN: zero-operand multiply, divide-by-zero and signed overflow skip BUSY.
module rv_muldiv_iter
  import rv_md_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic [7:0]      MD_type,
  output logic [XLEN-1:0] out,
  output logic            pending,
  output logic            valid
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  state_t          state_q;
  logic [2:0]      op_q;
  logic [7:0]      md_q;
  logic            sx_q, sy_q;
  logic            div0_q, ovf_q, mzero_q;
  logic [XLEN-1:0] a_q, hi_q, lo_q, x_q, res_q;
  logic [CW-1:0]   cnt_q;

  logic [2:0]      op_in;
  logic            sx_in, sy_in, div0_in, ovf_in, mzero_in, early_d;
  logic [XLEN-1:0] mag_x, mag_y, res_d;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s;

  always_comb begin
    op_in    = onehot_idx(MD_type);
    sx_in    = is_signed_x(op_in) & x[XLEN-1];
    sy_in    = is_signed_y(op_in) & y[XLEN-1];
    mag_x    = sx_in ? -x : x;
    mag_y    = sy_in ? -y : y;
    div0_in  = (y == '0);
    ovf_in   = sx_in && sy_in && (x == {1'b1, {(XLEN-1){1'b0}}}) && (y == '1);
    mzero_in = (x == '0) || (y == '0);
`ifdef RV_MD_EARLY_OUT_EN
    early_d  = is_div(op_in) ? (div0_in | ovf_in) : mzero_in;
`else
    early_d  = 1'b0;
`endif
  end

  logic [XLEN-1:0] hi_c [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] lo_c [BITS_PER_CYCLE+1];
  logic            div_op;

  assign div_op  = is_div(op_q);
  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    rv_md_step #(.XLEN(XLEN)) u_step (
      .is_div_i (div_op),
      .a_i      (a_q),
      .hi_i     (hi_c[g]),
      .lo_i     (lo_c[g]),
      .hi_o     (hi_c[g+1]),
      .lo_o     (lo_c[g+1])
    );
  end

  // Sign fix-up and result selection; special cases override the iterated value.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = (sx_q ^ sy_q) ? -prod : prod;
    quo_s  = (sx_q ^ sy_q) ? -lo_q : lo_q;
    rem_s  = sx_q ? -hi_q : hi_q;
    res_d  = '0;
    if (div_op) begin
      if (div0_q)     res_d = is_rem(op_q) ? x_q : '1;
      else if (ovf_q) res_d = is_rem(op_q) ? '0 : x_q;
      else            res_d = is_rem(op_q) ? rem_s : quo_s;
    end else if (!mzero_q) begin
      res_d = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      md_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mzero_q <= 1'b0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      x_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MD_type != '0) begin
            op_q    <= op_in;
            md_q    <= MD_type;
            sx_q    <= sx_in;
            sy_q    <= sy_in;
            div0_q  <= div0_in;
            ovf_q   <= ovf_in;
            mzero_q <= mzero_in;
            x_q     <= x;
            a_q     <= is_div(op_in) ? mag_y : mag_x;
            lo_q    <= is_div(op_in) ? mag_x : mag_y;
            hi_q    <= '0;
            cnt_q   <= CW'(N);
            state_q <= early_d ? ST_FIX : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (MD_type == '0) begin
            state_q <= ST_IDLE;
          end else begin
            hi_q  <= hi_c[BITS_PER_CYCLE];
            lo_q  <= lo_c[BITS_PER_CYCLE];
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (MD_type == '0) begin
            state_q <= ST_IDLE;
          end else begin
            res_q   <= res_d;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (MD_type == '0) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // rst gates pending so the sequencer is released in the same cycle even with MD_type still driven.
  assign pending = !rst && (((state_q == ST_IDLE) && (MD_type != '0)) ||
                            (state_q == ST_BUSY) || (state_q == ST_FIX));
  assign valid   = (state_q == ST_DONE);
  assign out     = valid ? res_q : '0;

  a_op_stable: assert property (@(posedge clk) disable iff (rst)
    ((state_q != ST_IDLE) && (MD_type != '0)) |-> (MD_type == md_q));

endmodule

// File: tb/tb_rv_muldiv_iter.sv
// Scoreboard bench: two units (1 and 4 bits per cycle) share stimulus; results and pending length
// are checked against an arithmetic reference model.
module tb_rv_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x, y;
  logic [7:0]  md;
  logic [31:0] out_w  [2];
  logic        pend_w [2];
  logic        vld_w  [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          op;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  rv_muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .MD_type(md),
    .out(out_w[0]), .pending(pend_w[0]), .valid(vld_w[0])
  );

  rv_muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .x(x), .y(y), .MD_type(md),
    .out(out_w[1]), .pending(pend_w[1]), .valid(vld_w[1])
  );

  function automatic logic [31:0] ref_result(int op, logic [31:0] a, logic [31:0] b);
    longint      xa, ya;
    logic [63:0] p;
    case (op)
      0, 1, 2, 3: begin
        xa = (op <= 2) ? longint'($signed(a)) : longint'({32'h0, a});
        ya = (op <= 1) ? longint'($signed(b)) : longint'({32'h0, b});
        p  = xa * ya;
        return (op == 0) ? p[31:0] : p[63:32];
      end
      4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(int op, logic [31:0] a, logic [31:0] b, int bpc);
    int lat;
    lat = 32 / bpc + 2;
`ifdef RV_MD_EARLY_OUT_EN
    if (op >= 4 && (b == 32'h0 ||
        ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) lat = 2;
    if (op < 4 && (a == 32'h0 || b == 32'h0)) lat = 2;
`endif
    return lat;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(int op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int   n;
    e.res = ref_result(op, a, b);
    e.op  = op;
    e.lat = ref_latency(op, a, b, 1);
    sb0.push_back(e);
    e.lat = ref_latency(op, a, b, 4);
    sb1.push_back(e);
    x = a;
    y = b;
    md = '0;
    md[op] = 1'b1;
    tick();
    // Operands must only be sampled in the accept cycle.
    x = $urandom;
    y = $urandom;
    n = 0;
    while (!vld_w[0] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL op_timeout op=%0d got no valid required valid within 200 cycles", op);
    end
    repeat ($urandom_range(0, 2)) tick();
    md = '0;
    tick();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic abort_op(int op, logic [31:0] a, logic [31:0] b, int hold);
    x = a;
    y = b;
    md = '0;
    md[op] = 1'b1;
    repeat (hold) tick();
    md = '0;
    tick();
    tick();
  endtask

  task automatic check_idle(string name);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pend_w[i] !== 1'b0 || vld_w[i] !== 1'b0 || out_w[i] !== 32'h0) begin
        errors++;
        $display("FAIL %s dut%0d pending=%b valid=%b out=%h required 0/0/00000000",
                 name, i, pend_w[i], vld_w[i], out_w[i]);
      end
    end
  endtask

  int   pcnt   [2] = '{0, 0};
  logic prev_v [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    exp_t e;
    logic have;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pcnt[i]   = 0;
        prev_v[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (vld_w[i] && !prev_v[i]) begin
          have = (i == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL unexpected_valid dut%0d out=%h required no result", i, out_w[i]);
          end else begin
            e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            if (out_w[i] !== e.res) begin
              errors++;
              $display("FAIL result dut%0d op=%0d got %h required %h", i, e.op, out_w[i], e.res);
            end
            checks++;
            if (pcnt[i] != e.lat) begin
              errors++;
              $display("FAIL pending_len dut%0d op=%0d got %0d required %0d", i, e.op, pcnt[i], e.lat);
            end
          end
        end
        checks++;
        if ((!vld_w[i] && out_w[i] !== 32'h0) || (vld_w[i] && pend_w[i])) begin
          errors++;
          $display("FAIL out_gating dut%0d valid=%b pending=%b out=%h required out=0 when idle, no pending with valid",
                   i, vld_w[i], pend_w[i], out_w[i]);
        end
        if (pend_w[i]) pcnt[i]++;
        else           pcnt[i] = 0;
        prev_v[i] = vld_w[i];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    md  = '0;
    x   = '0;
    y   = '0;
    repeat (3) tick();
    check_idle("reset_state");
    rst = 1'b0;
    tick();
    check_idle("post_reset_idle");

    run_op(0, 32'd7, 32'd6);
    run_op(1, 32'h8000_0000, 32'h8000_0000);
    run_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2, 32'hFFFF_FFFF, 32'd2);
    run_op(4, -32'sd7, 32'd2);
    run_op(6, -32'sd7, 32'd2);
    run_op(5, 32'd5, 32'd0);
    run_op(6, 32'd5, 32'd0);
    run_op(4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(7, 32'hFFFF_FFF0, 32'd0);

    abort_op(4, 32'd100, 32'd7, 8);
    abort_op(4, 32'd100, 32'd7, 9);
    run_op(0, 32'd3, 32'd3);

    // Asynchronous reset while both units are in BUSY.
    x = 32'd11;
    y = 32'd13;
    md = 8'h01;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check_idle("rst_mid_op");
    tick();
    md  = '0;
    rst = 1'b0;
    tick();

    run_op(0, 32'd9, 32'd9);

    for (int k = 0; k < 60; k++) begin
      run_op(int'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    repeat (3) tick();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending entries required 0/0", sb0.size(), sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
